// File: rtl/risc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC control unit: opcodes, FSM states,
// ALU encodings and instruction field positions.
package risc_ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_STOP   = 3'd6
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier for the multi-cycle control unit.
module ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       is_rtype,
  output logic       is_load,
  output logic       is_store,
  output logic       is_imm,
  output logic       is_halt,
  output logic       is_illegal
);

  // One-hot-ish class flags; anything not listed is illegal.
  always_comb begin
    is_rtype   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_imm     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB: is_rtype = 1'b1;
      OP_LW:          is_load  = 1'b1;
      OP_SW:          is_store = 1'b1;
      OP_ADDI:        is_imm   = 1'b1;
      OP_HALT:        is_halt  = 1'b1;
      default:        is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Optional single-step mode is enabled by defining CTRL_STEP_EN (adds the step port).
module multicycle_ctrl
  import risc_ctrl_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CTRL_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      instr,
  input  logic             dmem_ack,
  output logic [31:0]      imem_addr,
  output logic [4:0]       rf_raddr1,
  output logic [4:0]       rf_raddr2,
  output logic [4:0]       rf_waddr,
  output logic             rf_we,
  output logic             wb_sel_mem,
  output logic [1:0]       alu_op,
  output logic             alu_src_imm,
  output logic             alu_out_we,
  output logic             dmem_re,
  output logic             dmem_we,
  output logic [31:0]      imm,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             illegal
);

  localparam logic [31:0] PC_LAST = 32'(IMEM_WORDS * 4 - 4);

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic is_rtype_s, is_load_s, is_store_s, is_imm_s, is_halt_s, is_illegal_s;
  logic go_s;
  state_e after_retire_s;

  ctrl_decode u_decode (
    .opcode     (ir_q[OP_HI:OP_LO]),
    .is_rtype   (is_rtype_s),
    .is_load    (is_load_s),
    .is_store   (is_store_s),
    .is_imm     (is_imm_s),
    .is_halt    (is_halt_s),
    .is_illegal (is_illegal_s)
  );

`ifdef CTRL_STEP_EN
  assign go_s           = start | step;
  assign after_retire_s = S_IDLE;
`else
  assign go_s           = start;
  assign after_retire_s = S_FETCH;
`endif

  // State, PC, IR, retire counter and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      ir_q      <= 32'd0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing; retirement happens on WB or on a store's ack.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (go_s) state_d = S_FETCH;
        else      state_d = S_IDLE;
      end
      S_FETCH: begin
        ir_d    = instr;
        pc_d    = (pc_q == PC_LAST) ? 32'd0 : pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_halt_s) begin
          state_d = S_STOP;
        end else if (is_illegal_s) begin
          state_d   = S_STOP;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load_s || is_store_s) state_d = S_MEM;
        else                         state_d = S_WB;
      end
      S_MEM: begin
        if (!dmem_ack) begin
          state_d = S_MEM;
        end else if (is_load_s) begin
          state_d = S_WB;
        end else begin
          retired_d = retired_q + CNT_W'(1);
          state_d   = after_retire_s;
        end
      end
      S_WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = after_retire_s;
      end
      S_STOP:  state_d = S_STOP;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobes from state; field decodes follow IR in every state.
  always_comb begin
    rf_we       = (state_q == S_WB);
    wb_sel_mem  = (state_q == S_WB) && is_load_s;
    alu_out_we  = (state_q == S_EXEC);
    dmem_re     = (state_q == S_MEM) && is_load_s;
    dmem_we     = (state_q == S_MEM) && is_store_s;
    alu_op      = (ir_q[OP_HI:OP_LO] == OP_SUB) ? ALU_SUB : ALU_ADD;
    alu_src_imm = is_load_s | is_store_s | is_imm_s;
    rf_raddr1   = ir_q[RS_HI:RS_LO];
    rf_raddr2   = ir_q[RT_HI:RT_LO];
    rf_waddr    = is_rtype_s ? ir_q[RD_HI:RD_LO] : ir_q[RT_HI:RT_LO];
    imm         = sext16(ir_q[IMM_HI:IMM_LO]);
  end

  assign imem_addr = pc_q;
  assign retired   = retired_q;
  assign halted    = (state_q == S_STOP);
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed programs, expected write-back and
// store events queued up front and popped by an independent monitor.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
`ifdef CTRL_STEP_EN
  logic        step = 1'b0;
`endif
  logic [31:0] instr;
  logic        dmem_ack = 1'b0;
  logic [31:0] imem_addr;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic        rf_we, wb_sel_mem, alu_src_imm, alu_out_we, dmem_re, dmem_we;
  logic [1:0]  alu_op;
  logic [31:0] imm;
  logic [31:0] retired;
  logic        halted, illegal;

  logic [31:0] imem [256];
  assign instr = imem[imem_addr[9:2]];

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CTRL_STEP_EN
    .step(step),
`endif
    .instr(instr), .dmem_ack(dmem_ack), .imem_addr(imem_addr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_we(rf_we), .wb_sel_mem(wb_sel_mem), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .alu_out_we(alu_out_we),
    .dmem_re(dmem_re), .dmem_we(dmem_we), .imm(imm),
    .retired(retired), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [4:0]  addr;
    logic        wbmem;
    logic        srcimm;
    logic [1:0]  aluop;
    logic [31:0] imm;
    bit          chk_imm;
  } ev_t;

  ev_t sb_q[$];
  int  checks = 0;
  int  errors = 0;
  int  re_cnt = 0;
  int  ack_delay = 0;
  bit  ack_force = 1'b0;
  int  wcnt = 0;

  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_LW = 6'd2, OP_SW = 6'd3,
                         OP_ADDI = 6'd4, OP_HALT = 6'd63;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] v);
    return {op, rs, rt, v};
  endfunction

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic void exp_ev(bit st, logic [4:0] addr, logic wbmem, logic srcimm,
                                 logic [1:0] aluop, logic [31:0] v, bit chk);
    ev_t e;
    e.st = st; e.addr = addr; e.wbmem = wbmem; e.srcimm = srcimm;
    e.aluop = aluop; e.imm = v; e.chk_imm = chk;
    sb_q.push_back(e);
  endfunction

  // Data-memory responder: ack after ack_delay wait cycles of a request.
  always @(posedge clk) begin
    #2;
    if (dmem_re || dmem_we) begin
      dmem_ack = ack_force || (wcnt == ack_delay);
      wcnt++;
    end else begin
      dmem_ack = ack_force;
      wcnt = 0;
    end
  end

  // Monitor: every write-back or acknowledged store pops one expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      if (dmem_re) re_cnt++;
      if (rf_we || (dmem_we && dmem_ack)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", 32'(rf_waddr), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("ev_kind", 32'(dmem_we), 32'(e.st));
          check("ev_addr", 32'(e.st ? rf_raddr2 : rf_waddr), 32'(e.addr));
          check("ev_wb_sel_mem", 32'(wb_sel_mem), 32'(e.wbmem));
          check("ev_alu_src_imm", 32'(alu_src_imm), 32'(e.srcimm));
          check("ev_alu_op", 32'(alu_op), 32'(e.aluop));
          if (e.chk_imm) check("ev_imm", imm, e.imm);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = {OP_HALT, 26'd0};
    tick(1);
    rst_n = 1'b1;
    re_cnt = 0;
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Returns the cycle index (1 = first FETCH) at which halted is first seen.
  task automatic wait_halt(int budget, output int cyc);
    cyc = 1;
    while (!halted && cyc < budget) begin
      tick(1);
      cyc++;
    end
    if (!halted) check("halt_timeout", 32'(halted), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    for (int i = 0; i < 256; i++) imem[i] = {OP_HALT, 26'd0};
    tick(2);
    // Reset state
    check("rst_pc", imem_addr, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_strobes", 32'({rf_we, wb_sel_mem, alu_out_we, dmem_re, dmem_we}), 32'd0);
    check("rst_fields", 32'({rf_waddr, rf_raddr1, rf_raddr2, alu_op, alu_src_imm}), 32'd0);
    check("rst_imm", imm, 32'd0);

    // Single ADDI with timing, ack held high to show it is ignored outside MEM
    do_reset();
    ack_force = 1'b1;
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd10);
    exp_ev(1'b0, 5'd1, 1'b0, 1'b1, 2'd0, 32'd10, 1'b1);
    go();
    check("t1_fetch_pc", imem_addr, 32'd0);
    tick(3);
    check("t1_wb_rf_we", 32'(rf_we), 32'd1);
    check("t1_wb_pc", imem_addr, 32'd4);
    check("t1_wb_retired", retired, 32'd0);
    tick(1);
    check("t1_retired", retired, 32'd1);
    wait_halt(50, cyc);
    check("t1_halt_cyc", 32'(cyc), 32'd3);
    check("t1_final_pc", imem_addr, 32'd8);
    check("t1_illegal", 32'(illegal), 32'd0);
    check("t1_q_empty", 32'(sb_q.size()), 32'd0);
    ack_force = 1'b0;

    // Full program, zero wait states
    do_reset();
    ack_delay = 0;
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd10);
    imem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd20);
    imem[2] = enc_r(OP_ADD, 5'd1, 5'd2, 5'd3);
    imem[3] = enc_i(OP_SW, 5'd0, 5'd3, 16'd0);
    imem[4] = enc_i(OP_LW, 5'd0, 5'd4, 16'd0);
    imem[5] = enc_r(OP_SUB, 5'd4, 5'd1, 5'd5);
    exp_ev(1'b0, 5'd1, 1'b0, 1'b1, 2'd0, 32'd10, 1'b1);
    exp_ev(1'b0, 5'd2, 1'b0, 1'b1, 2'd0, 32'd20, 1'b1);
    exp_ev(1'b0, 5'd3, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    exp_ev(1'b1, 5'd3, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    exp_ev(1'b0, 5'd4, 1'b1, 1'b1, 2'd0, 32'd0, 1'b1);
    exp_ev(1'b0, 5'd5, 1'b0, 1'b0, 2'd1, 32'd0, 1'b0);
    go();
    wait_halt(200, cyc);
    check("t2_halt_cyc", 32'(cyc), 32'd28);
    check("t2_retired", retired, 32'd6);
    check("t2_illegal", 32'(illegal), 32'd0);
    check("t2_pc", imem_addr, 32'd28);
    check("t2_q_empty", 32'(sb_q.size()), 32'd0);

    // LW with three wait states
    do_reset();
    ack_delay = 3;
    imem[0] = enc_i(OP_LW, 5'd0, 5'd4, 16'd8);
    exp_ev(1'b0, 5'd4, 1'b1, 1'b1, 2'd0, 32'd8, 1'b1);
    go();
    wait_halt(100, cyc);
    check("t3_re_cycles", 32'(re_cnt), 32'd4);
    check("t3_halt_cyc", 32'(cyc), 32'd11);
    check("t3_retired", retired, 32'd1);
    check("t3_q_empty", 32'(sb_q.size()), 32'd0);

    // Illegal opcode 7 stops the core; a later start is ignored
    do_reset();
    ack_delay = 0;
    imem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'hFFFB);
    imem[1] = {6'd7, 26'd0};
    imem[2] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd6);
    exp_ev(1'b0, 5'd1, 1'b0, 1'b1, 2'd0, 32'hFFFF_FFFB, 1'b1);
    go();
    wait_halt(50, cyc);
    check("t4_halt_cyc", 32'(cyc), 32'd7);
    check("t4_illegal", 32'(illegal), 32'd1);
    check("t4_retired", retired, 32'd1);
    check("t4_pc", imem_addr, 32'd8);
    go();
    tick(10);
    check("t4_still_halted", 32'(halted), 32'd1);
    check("t4_retired_after", retired, 32'd1);
    check("t4_pc_after", imem_addr, 32'd8);
    check("t4_q_empty", 32'(sb_q.size()), 32'd0);

    // Reset during the MEM phase of a store
    do_reset();
    ack_delay = 1000;
    imem[0] = enc_i(OP_SW, 5'd0, 5'd3, 16'd4);
    go();
    k = 0;
    while (!dmem_we && k < 20) begin
      tick(1);
      k++;
    end
    check("t5_we_seen", 32'(dmem_we), 32'd1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_we_async_drop", 32'(dmem_we), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    check("t5_pc", imem_addr, 32'd0);
    check("t5_retired", retired, 32'd0);
    check("t5_halted", 32'(halted), 32'd0);
    check("t5_we_idle", 32'(dmem_we), 32'd0);
    check("t5_q_empty", 32'(sb_q.size()), 32'd0);

`ifdef CTRL_STEP_EN
    // Single-step: one instruction per step pulse, IDLE in between
    do_reset();
    ack_delay = 0;
    for (int i = 0; i < 3; i++) begin
      imem[i] = enc_i(OP_ADDI, 5'd0, 5'(i + 1), 16'(i + 1));
      exp_ev(1'b0, 5'(i + 1), 1'b0, 1'b1, 2'd0, 32'(i + 1), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(6);
      check("step_retired", retired, 32'(i + 1));
      check("step_pc", imem_addr, 32'(4 * (i + 1)));
      tick(3);
      check("step_idle_pc", imem_addr, 32'(4 * (i + 1)));
      check("step_idle_halted", 32'(halted), 32'd0);
    end
    check("step_q_empty", 32'(sb_q.size()), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the non-pipelined RISC core. It owns the PC and instruction register and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the instruction-memory address and the register-file, ALU and data-memory control strobes, and runs a request/acknowledge handshake with the data memory. It sits between the combinational instruction memory and the datapath and replaces hard-wired single-cycle control.

## Interface
- IMEM_WORDS, 256: instruction memory depth in words; PC wraps modulo IMEM_WORDS*4 bytes
- CNT_W, 32: width of retired-instruction counter
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin execution at current PC
- instr  in  32  instruction word from instruction memory (combinational read of imem_addr)
- dmem_ack  in  1  data memory completed the current request
- imem_addr  out  32  byte address to instruction memory (= pc)
- rf_raddr1 / rf_raddr2  out  5 each  ir[25:21] (rs), ir[20:16] (rt)
- rf_waddr  out  5  rd (ir[15:11]) for ADD/SUB; rt for ADDI/LW
- rf_we  out  1  register-file write strobe
- wb_sel_mem  out  1  1 = write back memory data, 0 = ALU result
- alu_op  out  2  0 ADD, 1 SUB
- alu_src_imm  out  1  ALU operand B = sign-extended ir[15:0]
- alu_out_we  out  1  datapath latches ALU result
- dmem_re / dmem_we  out  1 each  data memory read/write request
- imm  out  32  sign-extended ir[15:0]
- retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W
- halted  out  1  HALT reached
- illegal  out  1  sticky; HALT entered because of an undefined opcode

## Operation
- Opcodes ir[31:26]: ADD=0, SUB=1, LW=2, SW=3, ADDI=4, HALT=63; all others are illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, STOP.
- IDLE: start=1 -> FETCH. Otherwise stay in IDLE.
- FETCH: ir <= instr; pc <= (pc+4) mod (IMEM_WORDS*4); -> DECODE.
- DECODE: rf_raddr* valid. Next state: HALT opcode -> STOP; illegal opcode -> STOP with illegal<=1; otherwise -> EXEC.
- EXEC: alu_out_we=1. alu_op is 1 for SUB, 0 otherwise. alu_src_imm=1 for LW/SW/ADDI. Next: LW/SW -> MEM, else -> WB.
- MEM: dmem_re (LW) or dmem_we (SW) held high until the cycle dmem_ack=1. On ack: LW -> WB; SW -> FETCH with retired+1.
- WB: rf_we=1; wb_sel_mem=1 for LW; retired+1; -> FETCH.
- STOP: halted=1. Stays in STOP until reset. start is ignored.
- All-zero word decodes as ADD r0,r0,r0 and executes normally.
- Strobes are Moore outputs decoded from state and ir. pc, ir, state, retired and illegal are registers.

## Timing
- Reset values: state IDLE, pc 0, ir 0, retired 0, halted 0, illegal 0, every strobe 0. rf_*addr, imm and alu_op follow ir=0.
- Reset mid-operation returns to IDLE immediately. Any outstanding dmem request is dropped and dmem_re/dmem_we go low asynchronously.
- Cycles per instruction: ADD/SUB/ADDI take 4. SW takes 4+w and LW takes 5+w, where w is the number of MEM cycles with dmem_ack=0.
- dmem_ack in the first MEM cycle is legal (w=0). dmem_ack outside MEM is ignored.
- start asserted outside IDLE is ignored.
- PC wrap: pc=IMEM_WORDS*4-4 fetches, then pc becomes 0.

## Configuration
- CTRL_STEP_EN defined: adds input port step (1 bit).
  - After each retire, the FSM returns to IDLE instead of FETCH.
  - From IDLE, either start or step advances to FETCH.
  - Net effect: one instruction per step pulse.
- CTRL_STEP_EN undefined: no step port; the FSM free-runs from start until STOP.

## Structure
- Package risc_ctrl_pkg holds:
  - opcode localparams (OP_ADD..OP_HALT)
  - state enum
  - alu_op encodings
  - instruction field bit positions
- Sub-module ctrl_decode: combinational opcode -> {is_rtype, is_load, is_store, is_imm, is_halt, is_illegal}. Instantiated once.

## Test plan
- Reset then start with word0 = ADDI r1,r0,10 -> FETCH at cycle 1. WB at cycle 4 with rf_we=1, rf_waddr=1, alu_src_imm=1, imm=10. Then pc=4 and retired=1.
- Program ADDI r1,10; ADDI r2,20; ADD r3,r1,r2; SW r3,0(r0); LW r4,0(r0); SUB r5,r4,r1; HALT, with dmem_ack tied high -> halted after 25 cycles of execution, retired=6, illegal=0.
- LW with dmem_ack delayed 3 cycles -> dmem_re high for exactly 4 cycles. WB asserts with wb_sel_mem=1 and rf_waddr=4.
- Word with opcode 7 -> STOP after DECODE, illegal=1, retired unchanged. A later start has no effect.
- rst_n pulled low during MEM of SW -> dmem_we drops immediately. After release: state IDLE, pc=0.
- CTRL_STEP_EN build: three step pulses -> exactly three instructions retired, with the FSM in IDLE between pulses.
